present_enc_ctrl: RTL

Round controller and state/key register bank for the round-based, area-optimized PRESENT encryptor. It sits directly downstream of the 64-bit 2:1 state mux: it registers the mux output, drives the mux select, runs the key schedule and round counter, and wraps the core in valid/ready handshakes. The combinational round function (addRoundKey, sLayer, pLayer) stays outside this block. It consumes `state_q`/`round_key` and returns its result on the mux `in2` leg.

---
 rtl/present_pkg.sv | 28 ++
 rtl/present_enc_ctrl_if.sv | 26 ++
 rtl/present_sbox4.sv | 9 +
 rtl/present_enc_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants, S-box table and FSM type for the PRESENT encryptor.
// Define PRESENT_KEY128_EN to select the 128-bit key schedule (80-bit otherwise).
package present_pkg;
  localparam int STATE_W = 64;
  localparam int ROUNDS  = 31;
  localparam int KEY_ROT = 61;
`ifdef PRESENT_KEY128_EN
  localparam int KEY_W    = 128;
  localparam int NUM_SBOX = 2;
  localparam int CTR_LSB  = 62;
`else
  localparam int KEY_W    = 80;
  localparam int NUM_SBOX = 1;
  localparam int CTR_LSB  = 15;
`endif

  // Index 0 is the rightmost entry: S(0)=C ... S(F)=2.
  localparam logic [15:0][3:0] SBOX = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } present_ctrl_state_t;
endpackage

// File: rtl/present_enc_ctrl_if.sv
// Handshake and state-mux bundle between the PRESENT controller and its environment.
interface present_enc_ctrl_if;
  import present_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [KEY_W-1:0]   key;
  logic [STATE_W-1:0] state_d;
  logic               mux_sel;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] round_key;
  logic [4:0]         round_ctr;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] ciphertext;

  modport master (
    output in_valid, key, state_d, out_ready,
    input  in_ready, mux_sel, state_q, round_key, round_ctr, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, key, state_d, out_ready,
    output in_ready, mux_sel, state_q, round_key, round_ctr, out_valid, ciphertext
  );
endinterface

// File: rtl/present_sbox4.sv
// 4-bit PRESENT S-box, shared by the key schedule and the external sLayer.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = SBOX[din];
endmodule

// File: rtl/present_enc_ctrl.sv
// PRESENT round controller: state/key registers, key schedule, round counter, handshakes.
// Build option PRESENT_KEY128_EN selects the 128-bit key schedule.
module present_enc_ctrl
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  present_enc_ctrl_if.slave bus
);
  present_ctrl_state_t state, state_nxt;

  logic [STATE_W-1:0]        state_r;
  logic [KEY_W-1:0]          key_q, key_rot, key_nxt;
  logic [4:0]                ctr;
  logic [NUM_SBOX-1:0][3:0]  sbox_out;
  logic                      load, step, in_ready, out_valid, mux_sel;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mux_sel   = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        mux_sel = 1'b1;
        step    = 1'b1;
        if (ctr == 5'(ROUNDS)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Key schedule: rotate left, S-box on the top nibble(s), XOR in the round index.
  assign key_rot = {key_q[KEY_W-KEY_ROT-1:0], key_q[KEY_W-1 -: KEY_ROT]};

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    present_sbox4 u_sbox (
      .din  (key_rot[KEY_W-1-4*g -: 4]),
      .dout (sbox_out[g])
    );
  end

  always_comb begin
    key_nxt = key_rot;
    for (int g = 0; g < NUM_SBOX; g++) key_nxt[KEY_W-1-4*g -: 4] = sbox_out[g];
    key_nxt[CTR_LSB +: 5] = key_rot[CTR_LSB +: 5] ^ ctr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= '0;
      key_q   <= '0;
      ctr     <= '0;
    end else if (load) begin
      state_r <= bus.state_d;
      key_q   <= bus.key;
      ctr     <= 5'd1;
    end else if (step) begin
      state_r <= bus.state_d;
      key_q   <= key_nxt;
      ctr     <= (ctr == 5'(ROUNDS)) ? 5'd0 : ctr + 5'd1;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.mux_sel    = mux_sel;
  assign bus.state_q    = state_r;
  assign bus.round_key  = key_q[KEY_W-1 -: STATE_W];
  assign bus.round_ctr  = ctr;
  assign bus.ciphertext = state_r ^ key_q[KEY_W-1 -: STATE_W];
endmodule
